// File: rtl/axi_lite_clint_slave.sv
// axi_lite_clint_slave
//   AXI4-Lite target for the core-local interruptor (CLINT) register block.
//   It holds msip, mtimecmp and a free-running mtime. MTIP is a registered
//   unsigned compare (mtime >= mtimecmp). MSIP is msip bit 0.
//   One read and one write may be in flight, and they are independent.
//
// Parameters
//   TICK_DIV  clock cycles per mtime increment (1..65535)
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET     clock; synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, write data, write response
//   S_AXI_AR* / S_AXI_R*         read address, read data
//   MTIP, MSIP                   interrupt outputs to the core
//
// Configuration macro
//   CLINT_MTIME_WRITE_EN  If defined, the MTIME words accept byte-strobed
//                         writes. If undefined, MTIME writes are ignored and
//                         return SLVERR.
module axi_lite_clint_slave #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        MTIP,
  output logic        MSIP
);

  // Word indices, taken from ADDR[15:2]
  localparam logic [13:0] IDX_MSIP     = 14'h0000;
  localparam logic [13:0] IDX_CMP_LO   = 14'h1000;
  localparam logic [13:0] IDX_CMP_HI   = 14'h1001;
  localparam logic [13:0] IDX_MTIME_LO = 14'h2FFE;
  localparam logic [13:0] IDX_MTIME_HI = 14'h2FFF;

`ifdef CLINT_MTIME_WRITE_EN
  localparam bit MTIME_WRITABLE = 1'b1;
`else
  localparam bit MTIME_WRITABLE = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  logic        unused_bits;
  assign unused_bits = ^{S_AXI_AWADDR[31:16], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:16], S_AXI_ARADDR[1:0],
                         S_AXI_AWPROT, S_AXI_ARPROT};

  logic [15:0] presc_q;
  logic        tick;
  logic [63:0] mtime_q, mtime_inc, mtime_nxt, mtimecmp_q;
  logic        msip_q, mtip_q;

  w_state_t    w_state_q, w_next;
  logic        aw_held_q, w_held_q;
  logic [13:0] aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_rdy, w_rdy, aw_fire, w_fire, wr_commit, wr_ok;
  logic [1:0]  bresp_q;
  logic [13:0] wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  r_state_t    r_state_q, r_next;
  logic        ar_rdy, ar_fire, rd_ok;
  logic [31:0] rd_val, rdata_q;
  logic [1:0]  rresp_q;

  assign tick = (presc_q == 16'(TICK_DIV - 1));

  // A channel already held comes from its capture register; otherwise from the bus.
  assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[15:2];
  assign wr_data = w_held_q  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb = w_held_q  ? wstrb_q  : S_AXI_WSTRB;

  // ---- write FSM: next state and handshakes
  always_comb begin
    w_next    = w_state_q;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    wr_commit = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_rdy = !aw_held_q && !S_AXI_ARESET;
        w_rdy  = !w_held_q  && !S_AXI_ARESET;
        if ((aw_held_q || (S_AXI_AWVALID && aw_rdy)) &&
            (w_held_q  || (S_AXI_WVALID  && w_rdy))) begin
          w_next    = W_RESP;
          wr_commit = 1'b1;
        end
      end
      W_RESP: if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_fire = S_AXI_AWVALID && aw_rdy;
  assign w_fire  = S_AXI_WVALID  && w_rdy;

  always_comb begin
    case (wr_idx)
      IDX_MSIP, IDX_CMP_LO, IDX_CMP_HI: wr_ok = 1'b1;
      IDX_MTIME_LO, IDX_MTIME_HI:       wr_ok = MTIME_WRITABLE;
      default:                          wr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_next;
      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) aw_held_q <= 1'b1;
        if (w_fire)  w_held_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_fire) aw_idx_q <= S_AXI_AWADDR[15:2];
    if (w_fire) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

  // ---- timer and register file
  // Written MTIME bytes override the ticked value; unwritten bytes keep the tick.
  always_comb begin
    mtime_inc = mtime_q + 64'(tick);
    mtime_nxt = mtime_inc;
`ifdef CLINT_MTIME_WRITE_EN
    if (wr_commit && wr_idx == IDX_MTIME_LO)
      mtime_nxt[31:0]  = merge_bytes(mtime_inc[31:0], wr_data, wr_strb);
    if (wr_commit && wr_idx == IDX_MTIME_HI)
      mtime_nxt[63:32] = merge_bytes(mtime_inc[63:32], wr_data, wr_strb);
`endif
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      presc_q <= tick ? 16'd0 : presc_q + 16'd1;
      mtime_q <= mtime_nxt;
      mtip_q  <= (mtime_q >= mtimecmp_q);
      if (wr_commit) begin
        case (wr_idx)
          IDX_MSIP:   if (wr_strb[0]) msip_q <= wr_data[0];
          IDX_CMP_LO: mtimecmp_q[31:0]  <= merge_bytes(mtimecmp_q[31:0],  wr_data, wr_strb);
          IDX_CMP_HI: mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
          default: ;
        endcase
      end
    end
  end

  // ---- read FSM
  always_comb begin
    r_next = r_state_q;
    ar_rdy = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_rdy = !S_AXI_ARESET;
        if (S_AXI_ARVALID && ar_rdy) r_next = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_fire = S_AXI_ARVALID && ar_rdy;

  always_comb begin
    rd_val = 32'd0;
    rd_ok  = 1'b1;
    case (S_AXI_ARADDR[15:2])
      IDX_MSIP:     rd_val = {31'd0, msip_q};
      IDX_CMP_LO:   rd_val = mtimecmp_q[31:0];
      IDX_CMP_HI:   rd_val = mtimecmp_q[63:32];
      IDX_MTIME_LO: rd_val = mtime_q[31:0];
      IDX_MTIME_HI: rd_val = mtime_q[63:32];
      default:      rd_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_next;
      if (ar_fire) begin
        rdata_q <= rd_val;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = w_rdy;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign MTIP          = mtip_q;
  assign MSIP          = msip_q;

endmodule

// File: tb/tb_axi_lite_clint_slave.sv
// Testbench for axi_lite_clint_slave (TICK_DIV = 4). Directed steps plus a
// randomized register-access phase, checked against a behavioural model in
// which mtime is simply (clock edges since reset) / TICK_DIV.
module tb_axi_lite_clint_slave;
  localparam int unsigned TD = 4;
`ifdef CLINT_MTIME_WRITE_EN
  localparam bit MTW = 1'b1;
`else
  localparam bit MTW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, mtip, msip;
  logic [1:0]  bresp, rresp;

  axi_lite_clint_slave #(.TICK_DIV(TD)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .MTIP(mtip), .MSIP(msip)
  );

  always #5 clk = ~clk;

  // Clock edges since reset released
  int unsigned cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int          checks = 0, passes = 0, fails = 0;
  logic        msip_m;
  logic [63:0] cmp_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mtime_at(input int unsigned edges);
    return 64'(edges / TD);
  endfunction

  // {resp, data} expected for a read whose handshake follows 'hs' edges
  function automatic logic [33:0] exp_read(input logic [31:0] a, input int unsigned hs);
    logic [63:0] mt;
    logic [15:0] off;
    mt  = mtime_at(hs);
    off = a[15:0] & 16'hFFFC;
    case (off)
      16'h0000: return {2'b00, 31'd0, msip_m};
      16'h4000: return {2'b00, cmp_m[31:0]};
      16'h4004: return {2'b00, cmp_m[63:32]};
      16'hBFF8: return {2'b00, mt[31:0]};
      16'hBFFC: return {2'b00, mt[63:32]};
      default:  return {2'b10, 32'd0};
    endcase
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [31:0] a);
    logic [15:0] off;
    off = a[15:0] & 16'hFFFC;
    case (off)
      16'h0000, 16'h4000, 16'h4004: return 2'b00;
      16'hBFF8, 16'hBFFC:           return MTW ? 2'b00 : 2'b10;
      default:                      return 2'b10;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] off;
    off = a[15:0] & 16'hFFFC;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (off == 16'h4000) cmp_m[8*b +: 8]      = d[8*b +: 8];
        if (off == 16'h4004) cmp_m[32 + 8*b +: 8] = d[8*b +: 8];
      end
    end
    if (off == 16'h0000 && s[0]) msip_m = d[0];
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r, output int unsigned hs);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arready) check("ar_timeout", 0, 1);
    hs = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    @(negedge clk);
    check("rvalid_latency", rvalid, 1);
    d = rdata;
    r = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r);
    bit aw_done, w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      n++;
    end
    if (!(aw_done && w_done)) check("aw_w_timeout", 0, 1);
    @(negedge clk);
    check("bvalid_latency", bvalid, 1);
    r = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, d, rnd;
    logic [1:0]  rr, br;
    logic [3:0]  s;
    logic [33:0] e;
    int unsigned hs, hs2;
    bit          seen;

    rst = 1'b1;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    msip_m = 1'b0;
    cmp_m  = '1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", {mtip, msip}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);

    // Idle timer run
    repeat (40) @(posedge clk);
    #1;
    check("idle_mtip", mtip, 0);
    axi_read(32'hBFF8, rd, rr, hs);
    check("mtime_lo_idle", {rr, rd}, {2'b00, 32'(hs / TD)});
    check("mtime_lo_near10", (rd >= 9 && rd <= 12), 1);
    axi_read(32'hBFFC, rd, rr, hs);
    check("mtime_hi_idle", {rr, rd}, 34'd0);

    // Compare at 20
    axi_write(32'h4004, 32'd0, 4'hF, br);
    check("bresp_cmp_hi", br, 2'b00);
    model_write(32'h4004, 32'd0, 4'hF);
    axi_write(32'h4000, 32'd20, 4'hF, br);
    check("bresp_cmp_lo", br, 2'b00);
    model_write(32'h4000, 32'd20, 4'hF);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("mtip_track", mtip, (mtime_at(cyc - 1) >= cmp_m));
      if (mtip) seen = 1;
    end
    check("mtip_rose", seen, 1);
    @(posedge clk); #1;
    axi_write(32'h4000, 32'hFFFF_FFFF, 4'hF, br);
    model_write(32'h4000, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    check("mtip_drop", mtip, 0);
    @(posedge clk); #1;
    axi_write(32'h4004, 32'hFFFF_FFFF, 4'hF, br);
    model_write(32'h4004, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    check("mtip_low", mtip, 0);
    @(posedge clk); #1;

    // W leads AW by three cycles, B held off for five
    awaddr = 32'h4000; wdata = 32'h1234_5678; wstrb = 4'hF;
    wvalid = 1'b1;
    @(negedge clk);
    check("w_first_wready", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w_held_state", {wready, awready, bvalid}, 3'b010);
      @(posedge clk); #1;
    end
    awvalid = 1'b1;
    @(negedge clk);
    check("aw_late_ready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_stall", {bvalid, bresp, awready, wready}, 5'b10000);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    check("b_final", bvalid, 1);
    @(posedge clk); #1;
    bready = 1'b0;
    model_write(32'h4000, 32'h1234_5678, 4'hF);
    @(negedge clk);
    check("b_done", {bvalid, awready, wready}, 3'b011);
    @(posedge clk); #1;
    axi_read(32'h4000, rd, rr, hs);
    check("split_write_rd", {rr, rd}, exp_read(32'h4000, hs));
    axi_write(32'h4004, 32'h0000_00A5, 4'h1, br);
    model_write(32'h4004, 32'h0000_00A5, 4'h1);
    check("same_cycle_bresp", br, 2'b00);
    axi_read(32'h4004, rd, rr, hs);
    check("same_cycle_rd", {rr, rd}, exp_read(32'h4004, hs));

    // MSIP
    axi_write(32'h0000, 32'hFFFF_FFFF, 4'hF, br);
    model_write(32'h0000, 32'hFFFF_FFFF, 4'hF);
    check("msip_pin_set", msip, 1);
    axi_read(32'h0000, rd, rr, hs);
    check("msip_rd", {rr, rd}, 34'h1);
    axi_write(32'h0000, 32'h0, 4'h0, br);
    check("msip_nostrb_bresp", br, 2'b00);
    check("msip_nostrb_pin", msip, 1);

    // Unmapped
    axi_read(32'h1234, rd, rr, hs);
    check("unmapped_rd", {rr, rd}, {2'b10, 32'd0});
    axi_write(32'h8000, 32'hFFFF_FFFF, 4'hF, br);
    check("unmapped_bresp", br, 2'b10);
    axi_read(32'h4000, rd, rr, hs);
    check("unmapped_nochg_lo", {rr, rd}, exp_read(32'h4000, hs));
    axi_read(32'h4004, rd, rr, hs);
    check("unmapped_nochg_hi", {rr, rd}, exp_read(32'h4004, hs));
    check("unmapped_nochg_msip", msip, msip_m);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'h0000;
        1: a = 32'h4000;
        2: a = 32'h4004;
        3: a = 32'hBFF8;
        4: a = 32'hBFFC;
        default: begin
          a = {16'd0, 16'($urandom_range(0, 65535))};
          if (exp_bresp(a) != 2'b10 || (a[15:0] & 16'hFFFC) == 16'hBFF8 ||
              (a[15:0] & 16'hFFFC) == 16'hBFFC)
            a = 32'h1234;
        end
      endcase
      a = {rnd[31:16], a[15:2], rnd[1:0]};
      if ($urandom_range(0, 1) == 0 || (MTW && (exp_bresp(a) == 2'b00) &&
          ((a[15:0] & 16'hFFFC) == 16'hBFF8 || (a[15:0] & 16'hFFFC) == 16'hBFFC))) begin
        axi_read(a, rd, rr, hs);
        e = exp_read(a, hs);
        check("rand_rd", {rr, rd}, e);
      end else begin
        d = $urandom();
        if ($urandom_range(0, 2) == 0) d = 32'($urandom_range(0, 80));
        if ((a[15:0] & 16'hFFFC) == 16'h4004 && $urandom_range(0, 1) == 0) d = 32'd0;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, br);
        check("rand_bresp", br, exp_bresp(a));
        model_write(a, d, s);
        check("rand_msip_pin", msip, msip_m);
      end
      @(negedge clk);
      check("rand_mtip", mtip, (mtime_at(cyc - 1) >= cmp_m));
      @(posedge clk); #1;
    end

    // MTIME write
    axi_write(32'hBFF8, 32'h100, 4'hF, br);
    check("mtime_wr_bresp", br, MTW ? 2'b00 : 2'b10);
    axi_read(32'hBFF8, rd, rr, hs);
    check("mtime_wr_rresp", rr, 2'b00);
    if (MTW) begin
      check("mtime_wr_min", (rd >= 32'h100), 1);
    end else begin
      check("mtime_wr_ignored", rd, 32'(hs / TD));
      axi_read(32'hBFFC, rd, rr, hs2);
      check("mtime_hi_ignored", {rr, rd}, exp_read(32'hBFFC, hs2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
